// File: rtl/distance_fare_acc.sv
// Metered distance-fare generator: synchronises wheel pulses, counts distance and
// accumulates the distance fare in 4-digit BCD, saturating at 9999.
module distance_fare_acc #(
    parameter logic [15:0] START_FARE_BCD = 16'h0800,
    parameter logic [15:0] UNIT_FARE_BCD  = 16'h0020,
    parameter logic [7:0]  BASE_UNITS     = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        pause,
    input  logic        dist_pulse,
    output logic [15:0] distance_fare_bcd,
    output logic [15:0] distance_bcd,
    output logic        in_trip,
    output logic        max
);

    typedef enum logic [1:0] {StIdle, StBase, StMeter, StSat} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] fare_q, fare_d;
    logic [15:0] dist_q, dist_d;
    logic [7:0]  base_cnt_q, base_cnt_d;
    logic        in_trip_q, in_trip_d;
    logic        max_q, max_d;

    logic        pulse_edge;
    logic        unit_evt;
    logic [16:0] fare_sum;
    logic [16:0] dist_sum;
    logic [15:0] dist_inc;
    logic        fare_sat;

    // Four-digit BCD add; bit 16 is the carry out of the top digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        r[16] = c;
        return r;
    endfunction

    assign pulse_edge = sync2_q & ~prev_q;
    assign unit_evt   = pulse_edge & ~pause & (state_q != StIdle);

    assign fare_sum = bcd_add(fare_q, UNIT_FARE_BCD);
    assign dist_sum = bcd_add(dist_q, 16'h0001);
    // A carry out of 9999+1 is the only way to overflow, so hold at 9999.
    assign dist_inc = dist_sum[16] ? 16'h9999 : dist_sum[15:0];
    assign fare_sat = fare_sum[16] | (fare_sum[15:0] == 16'h9999);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= dist_pulse;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        fare_d     = fare_q;
        dist_d     = dist_q;
        base_cnt_d = base_cnt_q;

        if (clear) begin
            state_d    = StIdle;
            fare_d     = '0;
            dist_d     = '0;
            base_cnt_d = '0;
        end else if (start && (state_q == StIdle)) begin
            state_d    = StBase;
            fare_d     = START_FARE_BCD;
            dist_d     = '0;
            base_cnt_d = '0;
        end else if (unit_evt) begin
            dist_d = dist_inc;
            unique case (state_q)
                StBase: begin
                    base_cnt_d = base_cnt_q + 8'd1;
                    if ((base_cnt_q + 8'd1) == BASE_UNITS) begin
                        state_d = StMeter;
                    end
                end
                StMeter: begin
                    if (fare_sat) begin
                        fare_d  = 16'h9999;
                        state_d = StSat;
                    end else begin
                        fare_d = fare_sum[15:0];
                    end
                end
                default: begin
                    // StSat: distance only, fare stays frozen.
                end
            endcase
        end

        in_trip_d = (state_d != StIdle);
        max_d     = (state_d == StSat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fare_q     <= '0;
            dist_q     <= '0;
            base_cnt_q <= '0;
            in_trip_q  <= 1'b0;
            max_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fare_q     <= fare_d;
            dist_q     <= dist_d;
            base_cnt_q <= base_cnt_d;
            in_trip_q  <= in_trip_d;
            max_q      <= max_d;
        end
    end

    assign distance_fare_bcd = fare_q;
    assign distance_bcd      = dist_q;
    assign in_trip           = in_trip_q;
    assign max               = max_q;

endmodule
